// File: rtl/fpu_big_alu_seq.sv
// Multi-cycle sign-magnitude add/subtract, CHUNK bits per cycle, with a
// negation pass when |a| < |b|. Optional out_zero port: FPU_BIG_ALU_SEQ_ZERO_FLAG_EN.
module fpu_big_alu_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_sign,
  input  logic             b_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             result_sign
`ifdef FPU_BIG_ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r, diff_r, diff_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, eff_sub, a_sign_r;
  logic [CHUNK:0]   sl;
  logic             cout, last, res_zero;
  logic [WIDTH:0]   res_w;
  int               idx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One slice per cycle; in PASS2 the slice is ~diff + carry (two's-complement negate).
  always_comb begin
    idx  = int'(cnt) * CHUNK;
    last = (cnt == CW'(N - 1));
    sl   = '0;
    case (state)
      PASS1: begin
        if (eff_sub)
          sl = {1'b0, a_r[idx +: CHUNK]} - {1'b0, b_r[idx +: CHUNK]} - {{CHUNK{1'b0}}, carry};
        else
          sl = {1'b0, a_r[idx +: CHUNK]} + {1'b0, b_r[idx +: CHUNK]} + {{CHUNK{1'b0}}, carry};
      end
      PASS2:   sl = {1'b0, ~diff_r[idx +: CHUNK]} + {{CHUNK{1'b0}}, carry};
      default: sl = '0;
    endcase
    cout = sl[CHUNK];
    diff_nxt = diff_r;
    diff_nxt[idx +: CHUNK] = sl[CHUNK-1:0];
    res_w = (state == PASS1) ? {cout & ~eff_sub, diff_nxt} : {1'b0, diff_nxt};
    res_zero = (res_w == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = PASS1;
      PASS1: if (last) state_nxt = (eff_sub && cout) ? PASS2 : DONE;
      PASS2: if (last) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0; b_r <= '0; diff_r <= '0; cnt <= '0; carry <= 1'b0;
      eff_sub <= 1'b0; a_sign_r <= 1'b0; result <= '0; result_sign <= 1'b0;
`ifdef FPU_BIG_ALU_SEQ_ZERO_FLAG_EN
      out_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r      <= a;
          b_r      <= b;
          a_sign_r <= a_sign;
          eff_sub  <= a_sign ^ b_sign ^ op;
          cnt      <= '0;
          carry    <= 1'b0;
        end
        PASS1, PASS2: begin
          diff_r <= diff_nxt;
          carry  <= cout;
          cnt    <= cnt + 1'b1;
          if (last) begin
            cnt <= '0;
            if (state == PASS1 && eff_sub && cout) begin
              carry <= 1'b1;
            end else begin
              result      <= res_w;
              result_sign <= res_zero ? 1'b0 : (a_sign_r ^ (state == PASS2));
`ifdef FPU_BIG_ALU_SEQ_ZERO_FLAG_EN
              out_zero    <= res_zero;
`endif
            end
          end
        end
`ifdef FPU_BIG_ALU_SEQ_ZERO_FLAG_EN
        DONE: if (out_ready) out_zero <= 1'b0;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_big_alu_seq.sv
// Directed bench for fpu_big_alu_seq: 64/16 unit plus a 64/64 single-slice unit.
module tb_fpu_big_alu_seq;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_valid1 = 0, op = 0, a_sign = 0, b_sign = 0;
  logic        out_ready = 0, out_ready1 = 0;
  logic [63:0] a = '0, b = '0;
  logic        in_ready, out_valid, result_sign;
  logic [64:0] result;
  logic        in_ready1, out_valid1, result_sign1;
  logic [64:0] result1;
`ifdef FPU_BIG_ALU_SEQ_ZERO_FLAG_EN
  logic        out_zero, out_zero1;
`endif
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  fpu_big_alu_seq #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .a_sign(a_sign), .b_sign(b_sign), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_sign(result_sign)
`ifdef FPU_BIG_ALU_SEQ_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  fpu_big_alu_seq #(.WIDTH(64), .CHUNK(64)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .op(op),
    .a(a), .b(b), .a_sign(a_sign), .b_sign(b_sign), .out_valid(out_valid1),
    .out_ready(out_ready1), .result(result1), .result_sign(result_sign1)
`ifdef FPU_BIG_ALU_SEQ_ZERO_FLAG_EN
    , .out_zero(out_zero1)
`endif
  );

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer operands at negedge; the following posedge is the accept edge.
  task automatic start_op(input logic [63:0] av, input logic as, input logic [63:0] bv,
                          input logic bs, input logic o);
    @(negedge clk);
    a = av; a_sign = as; b = bv; b_sign = bs; op = o; in_valid = 1;
    chk("in_ready_before_accept", {64'b0, in_ready}, 65'd1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
      if (lat > 100) begin
        chk("timeout", 65'd0, 65'd1);
        break;
      end
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    chk({tag, "_in_ready_after"}, {64'b0, in_ready}, 65'd1);
    chk({tag, "_out_valid_after"}, {64'b0, out_valid}, 65'd0);
  endtask

  task automatic run_op(input string tag, input logic [63:0] av, input logic as,
                        input logic [63:0] bv, input logic bs, input logic o,
                        input logic [64:0] er, input logic es, input int elat);
    int lat;
    start_op(av, as, bv, bs, o);
    wait_done(lat);
    chk({tag, "_result"}, result, er);
    chk({tag, "_sign"}, {64'b0, result_sign}, {64'b0, es});
    chk({tag, "_latency"}, 65'(lat), 65'(elat));
`ifdef FPU_BIG_ALU_SEQ_ZERO_FLAG_EN
    chk({tag, "_zero"}, {64'b0, out_zero}, {64'b0, er == 65'd0});
`endif
    release_out(tag);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {64'b0, in_ready}, 65'd1);
    chk("rst_out_valid", {64'b0, out_valid}, 65'd0);
    chk("rst_result", result, 65'd0);
    chk("rst_sign", {64'b0, result_sign}, 65'd0);
    @(negedge clk); rst = 0;

    run_op("add_5_3",   64'd5, 0, 64'd3, 0, 0, 65'd8, 0, 4);
    run_op("sub_3_5",   64'd3, 0, 64'd5, 0, 1, 65'd2, 1, 8);
    run_op("add_max_1", 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd1, 0, 0,
           65'h1_0000_0000_0000_0000, 0, 4);
    run_op("add_neg7",  64'd7, 1, 64'd7, 1, 0, 65'd14, 1, 4);
    run_op("sub_7_7",   64'd7, 0, 64'd7, 0, 1, 65'd0, 0, 4);
    run_op("mix_n5_p3", 64'd5, 1, 64'd3, 0, 0, 65'd2, 1, 4);
    run_op("borrow_x",  64'h1_0000_0000, 0, 64'd1, 0, 1, 65'hFFFF_FFFF, 0, 4);
    run_op("neg_x",     64'd1, 0, 64'h1_0000_0000, 0, 1, 65'hFFFF_FFFF, 1, 8);
    run_op("zero_neg",  64'd0, 1, 64'd0, 1, 0, 65'd0, 0, 4);

    // Backpressure: result held, new offers ignored while DONE
    start_op(64'd5, 0, 64'd3, 0, 0);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0]; a = 64'(i * 1234567); b = 64'(i); op = ~op; a_sign = i[1];
      @(posedge clk); #1;
      chk("bp_out_valid", {64'b0, out_valid}, 65'd1);
      chk("bp_in_ready", {64'b0, in_ready}, 65'd0);
      chk("bp_result", result, 65'd8);
      chk("bp_sign", {64'b0, result_sign}, 65'd0);
    end
    @(negedge clk); in_valid = 0;
    release_out("bp");
    @(posedge clk); #1;
    chk("bp_no_accept", {64'b0, in_ready}, 65'd1);

    // Reset in the middle of PASS2
    start_op(64'd3, 0, 64'd5, 0, 1);
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("rstp2_in_ready", {64'b0, in_ready}, 65'd1);
    chk("rstp2_out_valid", {64'b0, out_valid}, 65'd0);
    chk("rstp2_result", result, 65'd0);
    @(negedge clk); rst = 0;
    run_op("after_rst", 64'd100, 0, 64'd58, 1, 0, 65'd42, 0, 4);

    // Single-slice instance: latency 1
    @(negedge clk);
    a = 64'd5; a_sign = 0; b = 64'd3; b_sign = 0; op = 0; in_valid1 = 1;
    chk("n1_in_ready", {64'b0, in_ready1}, 65'd1);
    @(posedge clk); #1 in_valid1 = 0;
    lat = 0;
    while (1) begin
      @(posedge clk); lat++; #1;
      if (out_valid1 || lat > 100) break;
    end
    chk("n1_out_valid", {64'b0, out_valid1}, 65'd1);
    chk("n1_latency", 65'(lat), 65'd1);
    chk("n1_result", result1, 65'd8);
    chk("n1_sign", {64'b0, result_sign1}, 65'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
